// File: rtl/pixel_fb_writer.sv
// rtl/pixel_fb_writer.sv - sprite pixel stream to framebuffer write port, with clipping, FIFO and clear engine
//
// Purpose: accepts (x, y, colour) pixel writes, clips off-screen pixels, buffers
// on-screen ones as {linear address, colour} in a small FIFO, and drains them to a
// registered single-port framebuffer write port. A clear engine fills the whole
// screen with one colour; pixels arriving during a clear are buffered and drawn
// after it.
//
// Optional feature macro: PIXEL_FB_TRANSPARENT_EN (colour 3'b000 pixels not written).
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   plot, x, y, colour   pixel write strobe and payload
//   ready                FIFO has room this cycle
//   clear_req            level request for a full-screen clear
//   clear_colour         fill colour latched at clear start
//   clear_done           one-cycle pulse after the last clear write
//   fb_addr/data/wren    registered framebuffer write port
//   busy                 clear in progress or FIFO non-empty
//   drop_count           saturating count of on-screen pixels lost to overflow

module pixel_fb_writer #(
    parameter int H_RES      = 320,
    parameter int V_RES      = 240,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 17
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              plot,
    input  logic [8:0]        x,
    input  logic [7:0]        y,
    input  logic [2:0]        colour,
    output logic              ready,
    input  logic              clear_req,
    input  logic [2:0]        clear_colour,
    output logic              clear_done,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [2:0]        fb_data,
    output logic              fb_wren,
    output logic              busy,
    output logic [7:0]        drop_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_STREAM = 2'd0;
    localparam logic [1:0] ST_CLEAR  = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]       H_RES_U   = 32'(H_RES);
    localparam logic [31:0]       V_RES_U   = 32'(V_RES);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [2:0]        clr_col_q, clr_col_d;
    logic              fb_wren_q, fb_wren_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [2:0]        fb_data_q, fb_data_d;
    logic              clear_done_q, clear_done_d;
    logic [7:0]        drop_q;

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [2:0]        fifo_col_q  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic              on_screen;
    logic              opaque;
    logic              accept;
    logic              push;
    logic              drop;
    logic              pop;
    logic [ADDR_W-1:0] push_addr;

    assign on_screen = (32'(x) < H_RES_U) && (32'(y) < V_RES_U);

`ifdef PIXEL_FB_TRANSPARENT_EN
    // Black is the sprite background key: such pixels vanish before the FIFO.
    assign opaque = (colour != 3'b000);
`else
    assign opaque = 1'b1;
`endif

    // ready comes from the registered count only, so it never depends on pop.
    assign ready     = (count_q != DEPTH_C);
    assign accept    = plot && on_screen && opaque;
    assign push      = accept && ready;
    assign drop      = accept && !ready;
    assign push_addr = ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);

    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        clr_col_d    = clr_col_q;
        fb_wren_d    = 1'b0;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
        clear_done_d = 1'b0;
        pop          = 1'b0;
        case (state_q)
            ST_STREAM: begin
                // A clear request takes priority over draining buffered pixels.
                if (clear_req) begin
                    clr_col_d  = clear_colour;
                    clr_addr_d = '0;
                    state_d    = ST_CLEAR;
                end else if (count_q != '0) begin
                    pop       = 1'b1;
                    fb_wren_d = 1'b1;
                    fb_addr_d = fifo_addr_q[rd_ptr_q];
                    fb_data_d = fifo_col_q[rd_ptr_q];
                end
            end
            ST_CLEAR: begin
                fb_wren_d  = 1'b1;
                fb_addr_d  = clr_addr_q;
                fb_data_d  = clr_col_q;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                clear_done_d = 1'b1;
                state_d      = ST_STREAM;
            end
            default: begin
                state_d = ST_STREAM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_STREAM;
            clr_addr_q   <= '0;
            clr_col_q    <= '0;
            fb_wren_q    <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            clr_col_q    <= clr_col_d;
            fb_wren_q    <= fb_wren_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            clear_done_q <= clear_done_d;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= push_addr;
            fifo_col_q[wr_ptr_q]  <= colour;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drop && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 1'b1;
            end
        end
    end

    assign fb_wren    = fb_wren_q;
    assign fb_addr    = fb_addr_q;
    assign fb_data    = fb_data_q;
    assign clear_done = clear_done_q;
    assign drop_count = drop_q;
    assign busy       = (state_q != ST_STREAM) || (count_q != '0);

endmodule

// File: tb/tb_pixel_fb_writer.sv
// tb/tb_pixel_fb_writer.sv - directed-vector bench for pixel_fb_writer (320x240 and 8x4 instances)

module tb_pixel_fb_writer;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    // 320x240 instance
    logic        b_plot = 1'b0;
    logic [8:0]  b_x = '0;
    logic [7:0]  b_y = '0;
    logic [2:0]  b_col = '0;
    logic        b_ready;
    logic        b_clr_req = 1'b0;
    logic [2:0]  b_clr_col = '0;
    logic        b_done;
    logic [16:0] b_addr;
    logic [2:0]  b_data;
    logic        b_wren;
    logic        b_busy;
    logic [7:0]  b_drop;

    // 8x4 instance
    logic        s_plot = 1'b0;
    logic [8:0]  s_x = '0;
    logic [7:0]  s_y = '0;
    logic [2:0]  s_col = '0;
    logic        s_ready;
    logic        s_clr_req = 1'b0;
    logic [2:0]  s_clr_col = '0;
    logic        s_done;
    logic [16:0] s_addr;
    logic [2:0]  s_data;
    logic        s_wren;
    logic        s_busy;
    logic [7:0]  s_drop;

    pixel_fb_writer u_big (
        .clk(clk), .resetn(resetn),
        .plot(b_plot), .x(b_x), .y(b_y), .colour(b_col), .ready(b_ready),
        .clear_req(b_clr_req), .clear_colour(b_clr_col), .clear_done(b_done),
        .fb_addr(b_addr), .fb_data(b_data), .fb_wren(b_wren),
        .busy(b_busy), .drop_count(b_drop)
    );

    pixel_fb_writer #(.H_RES(8), .V_RES(4), .FIFO_DEPTH(4), .ADDR_W(17)) u_small (
        .clk(clk), .resetn(resetn),
        .plot(s_plot), .x(s_x), .y(s_y), .colour(s_col), .ready(s_ready),
        .clear_req(s_clr_req), .clear_colour(s_clr_col), .clear_done(s_done),
        .fb_addr(s_addr), .fb_data(s_data), .fb_wren(s_wren),
        .busy(s_busy), .drop_count(s_drop)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic found;
        logic seen_wren;
        logic seen_done;

        // Reset values
        resetn = 1'b0;
        step();
        check("rst_wren", 32'(b_wren), 0);
        check("rst_addr", 32'(b_addr), 0);
        check("rst_data", 32'(b_data), 0);
        check("rst_done", 32'(b_done), 0);
        check("rst_drop", 32'(b_drop), 0);
        check("rst_busy", 32'(b_busy), 0);
        check("rst_ready", 32'(b_ready), 1);
        check("rst_s_wren", 32'(s_wren), 0);
        check("rst_s_ready", 32'(s_ready), 1);
        step();
        resetn = 1'b1;
        step();

        // Single pixel: x=5, y=2 -> 645
        b_plot = 1'b1; b_x = 9'd5; b_y = 8'd2; b_col = 3'b101;
        step();
        b_plot = 1'b0;
        check("px_n1_wren", 32'(b_wren), 0);
        check("px_n1_busy", 32'(b_busy), 1);
        step();
        check("px_n2_wren", 32'(b_wren), 1);
        check("px_n2_addr", 32'(b_addr), 645);
        check("px_n2_data", 32'(b_data), 5);
        check("px_n2_busy", 32'(b_busy), 0);
        step();
        check("px_n3_wren", 32'(b_wren), 0);

        // Burst of 28 pixels at x=100..127, y=10
        for (int i = 0; i < 30; i++) begin
            b_plot = (i < 28);
            b_x = 9'(100 + i); b_y = 8'd10; b_col = 3'(i);
            check("burst_ready", 32'(b_ready), 1);
            step();
            if (i >= 1 && i <= 28) begin
                check("burst_wren", 32'(b_wren), 1);
                check("burst_addr", 32'(b_addr), 32'(3300 + i - 1));
                check("burst_data", 32'(b_data), 32'((i - 1) % 8));
            end else begin
                check("burst_idle", 32'(b_wren), 0);
            end
        end
        b_plot = 1'b0;
        check("burst_drop", 32'(b_drop), 0);

        // Clipping: just off the right and bottom edges
        b_plot = 1'b1; b_x = 9'd320; b_y = 8'd0; b_col = 3'b111;
        step();
        b_x = 9'd0; b_y = 8'd240;
        step();
        b_plot = 1'b0;
        seen_wren = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen_wren = seen_wren | b_wren;
            step();
        end
        check("clip_wren", 32'(seen_wren), 0);
        check("clip_drop", 32'(b_drop), 0);
        check("clip_busy", 32'(b_busy), 0);

        // Last on-screen pixel (319, 239) -> 76799
        b_plot = 1'b1; b_x = 9'd319; b_y = 8'd239; b_col = 3'b011;
        step();
        b_plot = 1'b0;
        step();
        check("corner_wren", 32'(b_wren), 1);
        check("corner_addr", 32'(b_addr), 76799);
        check("corner_data", 32'(b_data), 3);
        step();

        // Black pixel: transparent only when the feature is built in
        b_plot = 1'b1; b_x = 9'd1; b_y = 8'd0; b_col = 3'b000;
        step();
        b_plot = 1'b0;
        step();
`ifdef PIXEL_FB_TRANSPARENT_EN
        check("black_wren", 32'(b_wren), 0);
`else
        check("black_wren", 32'(b_wren), 1);
        check("black_addr", 32'(b_addr), 1);
`endif
        check("black_drop", 32'(b_drop), 0);
        step();

        // Clear on 8x4: 32 writes of colour 2, then clear_done
        s_clr_req = 1'b1; s_clr_col = 3'b010;
        step();
        s_clr_req = 1'b0;
        check("clr_entry_wren", 32'(s_wren), 0);
        check("clr_entry_busy", 32'(s_busy), 1);
        for (int k = 0; k < 32; k++) begin
            step();
            check("clr_wren", 32'(s_wren), 1);
            check("clr_addr", 32'(s_addr), 32'(k));
            check("clr_data", 32'(s_data), 2);
            check("clr_nodone", 32'(s_done), 0);
        end
        check("clr_last_busy", 32'(s_busy), 1);
        step();
        check("clr_done", 32'(s_done), 1);
        check("clr_done_wren", 32'(s_wren), 0);
        step();
        check("clr_done_pulse", 32'(s_done), 0);
        check("clr_after_busy", 32'(s_busy), 0);

        // Overflow during clear: 6 pixels, 4 buffered, 2 dropped
        s_clr_req = 1'b1; s_clr_col = 3'b011;
        step();
        s_clr_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_plot = 1'b1; s_x = 9'(i); s_y = 8'd1; s_col = 3'(i + 1);
            check("ovf_ready", 32'(s_ready), (i < 4) ? 32'd1 : 32'd0);
            step();
        end
        s_plot = 1'b0;
        check("ovf_drop", 32'(s_drop), 2);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            if (s_done) found = 1'b1;
        end
        check("ovf_done_seen", 32'(found), 1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("ovf_wren", 32'(s_wren), 1);
            check("ovf_addr", 32'(s_addr), 32'(8 + i));
            check("ovf_data", 32'(s_data), 32'(i + 1));
        end
        step();
        check("ovf_end_wren", 32'(s_wren), 0);
        check("ovf_end_busy", 32'(s_busy), 0);

        // Reset mid-clear at address 10, with one pixel buffered
        s_clr_req = 1'b1; s_clr_col = 3'b110;
        step();
        s_clr_req = 1'b0;
        s_plot = 1'b1; s_x = 9'd1; s_y = 8'd1; s_col = 3'b111;
        step();
        s_plot = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("mid_addr", 32'(s_addr), 10);
        check("mid_wren", 32'(s_wren), 1);
        resetn = 1'b0;
        step();
        check("mid_rst_wren", 32'(s_wren), 0);
        check("mid_rst_busy", 32'(s_busy), 0);
        check("mid_rst_done", 32'(s_done), 0);
        check("mid_rst_ready", 32'(s_ready), 1);
        check("mid_rst_drop", 32'(s_drop), 0);
        resetn = 1'b1;
        seen_wren = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen_wren = seen_wren | s_wren;
            seen_done = seen_done | s_done;
        end
        check("mid_post_wren", 32'(seen_wren), 0);
        check("mid_post_done", 32'(seen_done), 0);
        check("mid_post_busy", 32'(s_busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
